// File: rtl/vga_timing_rx.sv
// vga_timing_rx
// Recovers the pixel position from a VGA hsync/vsync/rgb stream that shares
// the system clock. Checks line and frame timing, runs a lock FSM and emits
// one strobe per visible pixel with the recovered coordinate and colour.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   hsync, vsync active-low syncs from the generator
//   rgb          12-bit pixel colour
//   locked       lock FSM is in LOCKED
//   rx_valid     one-clock strobe per visible pixel while locked
//   rx_x, rx_y   recovered coordinate, qualified by rx_valid
//   rx_rgb       sampled colour, qualified by rx_valid
//   frame_start  pulse when the recovered position wraps to (0,0)
//   h_err/v_err  pulse on a horizontal/vertical timing violation
//   frame_cnt    frames completed while locked (wraps)
//
// Lock FSM
//   state    | meaning
//   UNLOCKED | no timing reference; waiting for a vsync fall
//   ACQUIRE  | one vsync fall seen; waiting for a clean second one
//   LOCKED   | timing verified; pixel strobes enabled
module vga_timing_rx #(
  parameter int CLKS_PER_PIXEL = 4,
  parameter int H_DISP = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_DISP = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [11:0] rgb,
  output logic        locked,
  output logic        rx_valid,
  output logic [9:0]  rx_x,
  output logic [9:0]  rx_y,
  output logic [11:0] rx_rgb,
  output logic        frame_start,
  output logic        h_err,
  output logic        v_err,
  output logic [7:0]  frame_cnt
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int PW      = (CLKS_PER_PIXEL > 2) ? $clog2(CLKS_PER_PIXEL) : 1;

  localparam logic [PW-1:0] PH_LAST   = PW'(CLKS_PER_PIXEL - 1);
  localparam logic [PW-1:0] PH_SAMPLE = PW'(CLKS_PER_PIXEL / 2);
  localparam logic [9:0]    H_LOAD    = 10'(H_DISP + H_FP);
  localparam logic [9:0]    H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]    H_VIS     = 10'(H_DISP);
  localparam logic [9:0]    V_LOAD    = 10'(V_DISP + V_FP);
  localparam logic [9:0]    V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]    V_VIS     = 10'(V_DISP);
  localparam logic [11:0]   HCLK_LINE = 12'(H_TOTAL * CLKS_PER_PIXEL);
  localparam logic [11:0]   HCLK_SYNC = 12'(H_SYNC * CLKS_PER_PIXEL);
  localparam logic [9:0]    VL_FRAME  = 10'(V_TOTAL);
  localparam logic [9:0]    VL_SYNC   = 10'(V_SYNC);

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_ACQUIRE  = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;

  logic          hs_q, vs_q;
  logic [PW-1:0] phase;
  logic [9:0]    h_cnt, v_cnt;
  logic [11:0]   hclk;
  logic [9:0]    vlines;
  logic          h_armed, v_armed;
  logic [1:0]    state, state_nxt;

  logic hf, hr, vf, vr;
  logic pix_tick, h_wrap, v_wrap, samp_pt;
  logic h_err_c, v_err_c, err_any, drop;

  assign hf = hs_q & ~hsync;
  assign hr = ~hs_q & hsync;
  assign vf = vs_q & ~vsync;
  assign vr = ~vs_q & vsync;

  // An HF reload takes precedence over a pixel tick, so no wrap is reported
  // on that cycle; likewise VF suppresses the frame wrap.
  assign pix_tick = (phase == PH_LAST);
  assign h_wrap   = pix_tick & ~hf & (h_cnt == H_LAST);
  assign v_wrap   = h_wrap & ~vf & (v_cnt == V_LAST);
  assign samp_pt  = (phase == PH_SAMPLE) & (h_cnt < H_VIS) & (v_cnt < V_VIS);

  // The armed flags mean "a reference edge has been seen"; the first HF/VF
  // after reset or loss of lock only starts the measurement.
  assign h_err_c = h_armed & ((hf & (hclk != HCLK_LINE)) | (hr & (hclk != HCLK_SYNC)));
  assign v_err_c = v_armed & ((vf & (vlines != VL_FRAME)) | (vr & (vlines != VL_SYNC)));
  assign err_any = h_err_c | v_err_c;
  assign drop    = err_any & (state != ST_UNLOCKED);

  assign locked = (state == ST_LOCKED);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_UNLOCKED: if (vf) state_nxt = ST_ACQUIRE;
      ST_ACQUIRE: begin
        if (err_any) state_nxt = ST_UNLOCKED;
        else if (vf) state_nxt = ST_LOCKED;
      end
      ST_LOCKED:   if (err_any) state_nxt = ST_UNLOCKED;
      default:     state_nxt = ST_UNLOCKED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      phase <= '0;
      h_cnt <= '0;
      v_cnt <= '0;
      state <= ST_UNLOCKED;
    end else begin
      hs_q  <= hsync;
      vs_q  <= vsync;
      state <= state_nxt;

      if (hf || pix_tick) phase <= '0;
      else                phase <= phase + 1'b1;

      if (hf)            h_cnt <= H_LOAD;
      else if (pix_tick) h_cnt <= (h_cnt == H_LAST) ? 10'd0 : h_cnt + 10'd1;

      if (vf)          v_cnt <= V_LOAD;
      else if (h_wrap) v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end
  end

  // Timing measurement. vlines restarts at VF including a wrap on that same
  // cycle, so a wrap coincident with VF is counted exactly once per frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hclk    <= '0;
      vlines  <= '0;
      h_armed <= 1'b0;
      v_armed <= 1'b0;
    end else begin
      if (hf)                    hclk <= 12'd1;
      else if (hclk != 12'hFFF)  hclk <= hclk + 12'd1;

      if (vf)                             vlines <= {9'd0, h_wrap};
      else if (h_wrap && vlines != 10'h3FF) vlines <= vlines + 10'd1;

      if (drop)    h_armed <= 1'b0;
      else if (hf) h_armed <= 1'b1;

      if (drop)    v_armed <= 1'b0;
      else if (vf) v_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid    <= 1'b0;
      rx_x        <= '0;
      rx_y        <= '0;
      rx_rgb      <= '0;
      frame_start <= 1'b0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      rx_valid    <= samp_pt & locked;
      frame_start <= v_wrap;
      h_err       <= h_err_c;
      v_err       <= v_err_c;
      // Captured values only move with a strobe so they hold between strobes.
      if (samp_pt && locked) begin
        rx_x   <= h_cnt;
        rx_y   <= v_cnt;
        rx_rgb <= rgb;
      end
      if (v_wrap && locked) frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_vga_timing_rx.sv
module tb_vga_timing_rx;

  // Reduced raster so a full frame is 16 x 11 pixels at 4 clocks per pixel.
  localparam int CPP = 4;
  localparam int HD = 8, HFP = 2, HS = 3, HBP = 3, HT = 16;
  localparam int VD = 6, VFP = 1, VS = 2, VBP = 2, VT = 11;
  localparam int NPIX = HD * VD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic [11:0] rgb = 12'h000;
  logic        locked, rx_valid, frame_start, h_err, v_err;
  logic [9:0]  rx_x, rx_y;
  logic [11:0] rx_rgb;
  logic [7:0]  frame_cnt;

  int errors = 0;
  int checks = 0;

  vga_timing_rx #(
    .CLKS_PER_PIXEL(CPP), .H_DISP(HD), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_DISP(VD), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .locked(locked), .rx_valid(rx_valid), .rx_x(rx_x), .rx_y(rx_y),
    .rx_rgb(rx_rgb), .frame_start(frame_start), .h_err(h_err), .v_err(v_err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] pat(input logic [9:0] x, input logic [9:0] y);
    return {y[3:0], x[3:0], x[3:0] ^ y[3:0]};
  endfunction

  // Output monitor: counts events and records strobe coordinates.
  int          n_cyc = 0, n_strobe = 0, n_herr = 0, n_verr = 0, n_fs = 0;
  int          pat_bad = 0, gap_bad = 0, prev_cyc = 0;
  bit          have_prev = 1'b0;
  logic [9:0]  prev_x = '0, prev_y = '0;
  logic [19:0] sq[$];

  always @(negedge clk) begin
    n_cyc <= n_cyc + 1;
    if (rx_valid === 1'b1) begin
      sq.push_back({rx_x, rx_y});
      n_strobe <= n_strobe + 1;
      if (rx_rgb !== pat(rx_x, rx_y)) pat_bad <= pat_bad + 1;
      if (have_prev && rx_y == prev_y && rx_x == prev_x + 10'd1 && (n_cyc - prev_cyc) != CPP)
        gap_bad <= gap_bad + 1;
      have_prev <= 1'b1;
      prev_x    <= rx_x;
      prev_y    <= rx_y;
      prev_cyc  <= n_cyc;
    end
    if (h_err === 1'b1)       n_herr <= n_herr + 1;
    if (v_err === 1'b1)       n_verr <= n_verr + 1;
    if (frame_start === 1'b1) n_fs <= n_fs + 1;
  end

  // ---------------- generator ----------------
  task automatic drive_pix(input int x, input int y, input int nvs);
    for (int c = 0; c < CPP; c++) begin
      @(posedge clk); #1;
      hsync = !(x >= HD + HFP && x < HD + HFP + HS);
      vsync = !(y >= VD + VFP && y < VD + VFP + nvs);
      rgb   = (x < HD && y < VD) ? pat(10'(x), 10'(y)) : 12'h000;
    end
  endtask

  // stretch_line gets one extra front-porch pixel; stop_line/stop_pix end
  // the frame early just before that pixel (-1 for a complete frame).
  task automatic drive_frame(input int nvs, input int stretch_line,
                             input int stop_line, input int stop_pix);
    int np, x;
    for (int y = 0; y < VT; y++) begin
      np = (y == stretch_line) ? HT + 1 : HT;
      for (int p = 0; p < np; p++) begin
        x = (y == stretch_line && p > HD) ? p - 1 : p;
        if (y == stop_line && x == stop_pix) return;
        drive_pix(x, y, nvs);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      hsync = 1'b1; vsync = 1'b1; rgb = 12'h000;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    checks++; if ({rx_x, rx_y, rx_rgb} !== 32'h0) begin errors++; $display("FAIL reset_rx_data: got %h expected 0", {rx_x, rx_y, rx_rgb}); end
    checks++; if ({frame_start, h_err, v_err} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b expected 000", {frame_start, h_err, v_err}); end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_lock;
    int s, f, qi;
    s = n_strobe;
    drive_frame(VS, -1, -1, -1);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_after_vf1: got %b expected 0", locked); end
    drive_frame(VS, -1, -1, -1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_after_vf2: got %b expected 1", locked); end
    checks++; if (n_strobe - s !== 0) begin errors++; $display("FAIL lock_no_early_strobe: got %0d expected 0", n_strobe - s); end
    s = n_strobe; f = n_fs; qi = sq.size();
    drive_frame(VS, -1, -1, -1);
    checks++; if (n_strobe - s !== NPIX) begin errors++; $display("FAIL lock_strobes: got %0d expected %0d", n_strobe - s, NPIX); end
    checks++; if (sq.size() <= qi || sq[qi] !== 20'h0) begin errors++; $display("FAIL lock_first_xy: got %h expected 00000", sq[qi]); end
    checks++; if (sq[sq.size()-1] !== {10'(HD-1), 10'(VD-1)}) begin errors++; $display("FAIL lock_last_xy: got %h expected %h", sq[sq.size()-1], {10'(HD-1), 10'(VD-1)}); end
    checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL lock_frame_cnt: got %0d expected 1", frame_cnt); end
    checks++; if (n_fs - f !== 1) begin errors++; $display("FAIL lock_frame_start: got %0d expected 1", n_fs - f); end
    checks++; if (n_herr + n_verr !== 0) begin errors++; $display("FAIL lock_no_errors: got %0d expected 0", n_herr + n_verr); end
  endtask

  task automatic test_pattern;
    int s, p, g;
    s = n_strobe; p = pat_bad; g = gap_bad;
    drive_frame(VS, -1, -1, -1);
    checks++; if (n_strobe - s !== NPIX) begin errors++; $display("FAIL pattern_strobes: got %0d expected %0d", n_strobe - s, NPIX); end
    checks++; if (pat_bad !== 0) begin errors++; $display("FAIL pattern_rgb: got %0d bad expected 0", pat_bad); end
    checks++; if (gap_bad - g !== 0) begin errors++; $display("FAIL pattern_period: got %0d bad expected 0", gap_bad - g); end
    checks++; if ({rx_x, rx_y} !== {10'(HD-1), 10'(VD-1)}) begin errors++; $display("FAIL pattern_hold_xy: got %h expected %h", {rx_x, rx_y}, {10'(HD-1), 10'(VD-1)}); end
    checks++; if (rx_rgb !== pat(10'(HD-1), 10'(VD-1))) begin errors++; $display("FAIL pattern_hold_rgb: got %h expected %h", rx_rgb, pat(10'(HD-1), 10'(VD-1))); end
    checks++; if (frame_cnt !== 8'd2) begin errors++; $display("FAIL pattern_frame_cnt: got %0d expected 2", frame_cnt); end
  endtask

  task automatic test_stretch;
    int s, he, ve;
    s = n_strobe; he = n_herr; ve = n_verr;
    drive_frame(VS, 2, -1, -1);
    checks++; if (n_herr - he !== 1) begin errors++; $display("FAIL stretch_h_err: got %0d expected 1", n_herr - he); end
    checks++; if (n_verr - ve !== 0) begin errors++; $display("FAIL stretch_v_err: got %0d expected 0", n_verr - ve); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL stretch_unlock: got %b expected 0", locked); end
    checks++; if (n_strobe - s !== 3 * HD) begin errors++; $display("FAIL stretch_strobes: got %0d expected %0d", n_strobe - s, 3 * HD); end
    s = n_strobe;
    drive_frame(VS, -1, -1, -1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL stretch_relock: got %b expected 1", locked); end
    checks++; if (n_strobe - s !== 0) begin errors++; $display("FAIL stretch_acq_strobes: got %0d expected 0", n_strobe - s); end
    s = n_strobe;
    drive_frame(VS, -1, -1, -1);
    checks++; if (n_strobe - s !== NPIX) begin errors++; $display("FAIL stretch_after_strobes: got %0d expected %0d", n_strobe - s, NPIX); end
    checks++; if (frame_cnt !== 8'd4) begin errors++; $display("FAIL stretch_frame_cnt: got %0d expected 4", frame_cnt); end
    checks++; if (n_herr - he !== 1) begin errors++; $display("FAIL stretch_single_err: got %0d expected 1", n_herr - he); end
  endtask

  task automatic test_vsync_long;
    int s, he, ve;
    s = n_strobe; he = n_herr; ve = n_verr;
    drive_frame(3, -1, -1, -1);
    checks++; if (n_verr - ve !== 1) begin errors++; $display("FAIL vlong_v_err: got %0d expected 1", n_verr - ve); end
    checks++; if (n_herr - he !== 0) begin errors++; $display("FAIL vlong_h_err: got %0d expected 0", n_herr - he); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL vlong_unlock: got %b expected 0", locked); end
    checks++; if (n_strobe - s !== NPIX) begin errors++; $display("FAIL vlong_strobes: got %0d expected %0d", n_strobe - s, NPIX); end
    s = n_strobe;
    drive_frame(VS, -1, -1, -1);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL vlong_acquire: got %b expected 0", locked); end
    drive_frame(VS, -1, -1, -1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL vlong_relock: got %b expected 1", locked); end
    checks++; if (n_strobe - s !== 0) begin errors++; $display("FAIL vlong_no_strobe: got %0d expected 0", n_strobe - s); end
    drive_frame(VS, -1, -1, -1);
    checks++; if (frame_cnt !== 8'd6) begin errors++; $display("FAIL vlong_frame_cnt: got %0d expected 6", frame_cnt); end
    checks++; if (n_verr - ve !== 1) begin errors++; $display("FAIL vlong_single_err: got %0d expected 1", n_verr - ve); end
  endtask

  task automatic test_reset_midframe;
    int s, qi;
    drive_frame(VS, -1, 3, HD / 2);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if ({locked, rx_valid, frame_start, h_err, v_err} !== 5'b0) begin errors++; $display("FAIL midrst_flags: got %b expected 00000", {locked, rx_valid, frame_start, h_err, v_err}); end
    checks++; if ({rx_x, rx_y, rx_rgb} !== 32'h0) begin errors++; $display("FAIL midrst_rx_data: got %h expected 0", {rx_x, rx_y, rx_rgb}); end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL midrst_frame_cnt: got %0d expected 0", frame_cnt); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    s = n_strobe;
    drive_frame(VS, -1, -1, -1);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL midrst_vf1: got %b expected 0", locked); end
    drive_frame(VS, -1, -1, -1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL midrst_vf2: got %b expected 1", locked); end
    checks++; if (n_strobe - s !== 0) begin errors++; $display("FAIL midrst_no_strobe: got %0d expected 0", n_strobe - s); end
    s = n_strobe; qi = sq.size();
    drive_frame(VS, -1, -1, -1);
    checks++; if (n_strobe - s !== NPIX) begin errors++; $display("FAIL midrst_strobes: got %0d expected %0d", n_strobe - s, NPIX); end
    checks++; if (sq.size() <= qi || sq[qi] !== 20'h0) begin errors++; $display("FAIL midrst_first_xy: got %h expected 00000", sq[qi]); end
    checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL midrst_frame_cnt: got %0d expected 1", frame_cnt); end
  endtask

  // The last HF of the previous frame sits 24 clocks before the frame end;
  // 4136 idle clocks make the next HF period 4160 = 4096 + 64, which only a
  // saturating period counter reports as wrong.
  task automatic test_hsync_stuck;
    int he, ve;
    he = n_herr; ve = n_verr;
    idle(4136);
    checks++; if (n_herr - he !== 0) begin errors++; $display("FAIL stuck_no_h_err: got %0d expected 0", n_herr - he); end
    checks++; if (n_verr - ve !== 0) begin errors++; $display("FAIL stuck_no_v_err: got %0d expected 0", n_verr - ve); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL stuck_still_locked: got %b expected 1", locked); end
    for (int i = 0; i < HS * CPP + 4; i++) begin
      @(posedge clk); #1;
      hsync = (i >= HS * CPP);
    end
    checks++; if (n_herr - he !== 1) begin errors++; $display("FAIL stuck_saturated_h_err: got %0d expected 1", n_herr - he); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL stuck_unlock: got %b expected 0", locked); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_pattern();
    test_stretch();
    test_vsync_long();
    test_reset_midframe();
    test_hsync_stuck();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
